// File: rtl/cube_pow_pkg.sv
// cube_pow_pkg: shared width constants and helpers for the cube unit
package cube_pow_pkg;

    localparam int CUBE_W = 8;

    function automatic int prod_w(input int w);
        return 3 * w;
    endfunction

endpackage

// File: rtl/cube_pow_if.sv
// cube_pow_if: start/busy request bus carrying the operand and the cube result
interface cube_pow_if import cube_pow_pkg::*; #(
    parameter int W = CUBE_W
);
    logic [W-1:0]   x;
    logic           start;
    logic           busy;
    logic [3*W-1:0] y;

    modport master (output x, start, input busy, y);
    modport slave  (input x, start, output busy, y);
endinterface

// File: rtl/cube_pow_mul.sv
// mul_seq: sequential shift-add multiplier, one multiplier bit per cycle, LSB first
module mul_seq #(
    parameter int WA = 16,
    parameter int WB = 8,
    parameter int WP = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    output logic          busy,
    output logic [WP-1:0] p
);
    localparam int CW = $clog2(WB + 1);

    logic [WP-1:0] a_sh;
    logic [WB-1:0] b_sh;
    logic [WP-1:0] acc;
    logic [WP-1:0] sum;
    logic [CW-1:0] cnt;

    // a_sh holds A shifted by the current bit index, so adding it is the partial product
    always_comb sum = acc + (b_sh[0] ? a_sh : '0);

    // accept when idle, then W iterations; product lands on the last one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            p    <= '0;
        end else if (!busy) begin
            if (start) begin
                a_sh <= WP'(a);
                b_sh <= b;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end
        end else begin
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            acc  <= sum;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(WB - 1)) begin
                busy <= 1'b0;
                p    <= sum;
            end
        end
    end

endmodule

// File: rtl/cube_pow.sv
// cube_pow: iterative y = x^3 using one shared multiplier twice (x*x, then x^2*x)
module cube_pow import cube_pow_pkg::*; #(
    parameter int W = CUBE_W
) (
    input  logic      clk,
    input  logic      rst,
    cube_pow_if.slave bus
);
    localparam int WP = prod_w(W);

    typedef enum logic [2:0] {IDLE, SQ, SQ_WAIT, CB, CB_WAIT} state_t;

    state_t          state;
    logic [W-1:0]    xr;
    logic [2*W-1:0]  sq;
    logic [WP-1:0]   y_r;
    logic            m_start;
    logic [2*W-1:0]  m_a;
    logic            m_busy;
    logic [WP-1:0]   m_p;

    // multiplier is kicked for the single cycle spent in SQ or CB; A is x then x^2
    always_comb begin
        m_start = (state == SQ) || (state == CB);
        m_a     = (state == CB) ? sq : {{W{1'b0}}, xr};
    end

    assign bus.busy = (state != IDLE);
    assign bus.y    = y_r;

    mul_seq #(.WA(2*W), .WB(W), .WP(WP)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (m_start),
        .a     (m_a),
        .b     (xr),
        .busy  (m_busy),
        .p     (m_p)
    );

    // sequencer: square, then cube; y only changes when a cube completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xr    <= '0;
            sq    <= '0;
            y_r   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    xr    <= bus.x;
                    state <= SQ;
                end
                SQ: state <= SQ_WAIT;
                SQ_WAIT: if (!m_busy) begin
                    sq    <= m_p[2*W-1:0];
                    state <= CB;
                end
                CB: state <= CB_WAIT;
                CB_WAIT: if (!m_busy) begin
                    y_r   <= m_p;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_pow.sv
// tb_cube_pow: directed checks of cube_pow against a cycle-count/arithmetic model
module tb_cube_pow;
    localparam int W   = 8;
    localparam int LAT = 2 * W + 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    cube_pow_if #(.W(W)) bus ();

    cube_pow #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: a request is taken only when idle, result is x^3 exactly LAT cycles later
    logic         m_busy;
    int           m_cnt;
    logic [23:0]  m_y;
    logic [23:0]  m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_y    <= '0;
            m_pend <= '0;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_y    <= m_pend;
            end
        end else if (bus.start) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT;
            m_pend <= 24'(longint'(bus.x) * bus.x * bus.x);
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", longint'(bus.busy), longint'(m_busy));
        chk("cyc_y", longint'(bus.y), longint'(m_y));
    end

    // issues one request at the current time and returns how many cycles busy stayed high;
    // if glitch>0 a start with x=5 is pulsed at that cycle of the busy window
    task automatic issue(input logic [W-1:0] v, input int glitch, output int n);
        bus.x     = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            if (glitch > 0 && n == glitch) begin
                bus.start = 1'b1;
                bus.x     = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
    endtask

    function automatic longint icbrt(input longint v);
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    int n;

    initial begin
        rst       = 1'b1;
        bus.x     = '0;
        bus.start = 1'b0;
        #22;
        rst = 1'b0;
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_y", longint'(bus.y), 0);

        @(posedge clk);
        #1;
        issue(8'd3, 0, n);
        chk("lat_3", n, 20);
        chk("y_3", longint'(bus.y), 27);
        chk("model_y_3", longint'(m_y), 27);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_3", longint'(bus.y), 27);

        issue(8'd0, 0, n);
        chk("lat_0", n, 20);
        chk("y_0", longint'(bus.y), 0);
        issue(8'd1, 0, n);
        chk("y_1", longint'(bus.y), 1);
        issue(8'd255, 0, n);
        chk("y_255", longint'(bus.y), 16581375);
        chk("model_y_255", longint'(m_y), 16581375);

        @(posedge clk);
        #1;
        issue(8'd200, 7, n);
        chk("lat_ign", n, 20);
        chk("y_200", longint'(bus.y), 8000000);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_idle", longint'(bus.busy), 0);

        bus.x     = 8'd123;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", longint'(bus.busy), 0);
        chk("arst_y", longint'(bus.y), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(8'd4, 0, n);
        chk("lat_4", n, 20);
        chk("y_4", longint'(bus.y), 64);

        issue(8'd7, 0, n);
        chk("y_7", longint'(bus.y), 343);
        issue(8'd9, 0, n);
        chk("b2b_lat", n, 20);
        chk("y_9", longint'(bus.y), 729);
        chk("model_y_9", longint'(m_y), 729);

        for (int i = 0; i < 8; i++) begin
            issue(W'(i), 0, n);
            chk("rt_lat", n, 20);
            chk("rt_root", icbrt(longint'(bus.y)), i);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
